// File: rtl/regfile_mp.sv
// Parametrised register file: one write port, NRD registered read ports,
// optional hardwired-zero register 0 and same-edge write-to-read forwarding.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 We,
  input  logic [AW-1:0]        Waddr,
  input  logic [WIDTH-1:0]     Wdata,
  input  logic [NRD-1:0]       Re,
  input  logic [NRD*AW-1:0]    Raddr,
  output logic [NRD*WIDTH-1:0] Rdata,
  output logic [NRD-1:0]       Rvalid,
  output logic                 Addr_err
);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [NRD*WIDTH-1:0] r_rdata;
  logic [NRD-1:0]       r_rvalid;
  logic                 r_addr_err;

  logic                 w_wr_in_range;
  logic                 w_wr_legal;
  logic                 w_addr_err;
  logic [NRD-1:0]       w_rd_in_range;
  logic [AW-1:0]        w_raddr   [NRD];
  logic [WIDTH-1:0]     w_rd_next [NRD];

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_wr_in_range = (32'(Waddr) < 32'(DEPTH));
    w_wr_legal    = We && w_wr_in_range && !((ZERO_REG != 0) && (Waddr == '0));
    w_addr_err    = We && !w_wr_in_range;
    w_rd_in_range = '0;
    for (int i = 0; i < NRD; i++) begin
      w_raddr[i]       = Raddr[i*AW +: AW];
      w_rd_in_range[i] = (32'(w_raddr[i]) < 32'(DEPTH));
      w_rd_next[i]     = '0;
      // Out-of-range and hardwired-zero reads both return zero.
      if (w_rd_in_range[i] && !((ZERO_REG != 0) && (w_raddr[i] == '0))) begin
        if ((BYPASS != 0) && w_wr_legal && (Waddr == w_raddr[i]))
          w_rd_next[i] = Wdata;
        else
          w_rd_next[i] = r_mem[w_raddr[i]];
      end
      if (Re[i] && !w_rd_in_range[i])
        w_addr_err = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, which is what makes the non-bypass read old data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      // NOTE: the storage array is reset too, since reads after reset must
      // return zero; this costs a reset net on every storage flop.
      for (int d = 0; d < DEPTH; d++)
        r_mem[d] <= '0;
      r_rdata    <= '0;
      r_rvalid   <= '0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_wr_legal)
        r_mem[Waddr] <= Wdata;
      for (int i = 0; i < NRD; i++) begin
        if (Re[i])
          r_rdata[i*WIDTH +: WIDTH] <= w_rd_next[i];
      end
      r_rvalid   <= Re;
      r_addr_err <= w_addr_err;
    end
  end

  assign Rdata    = r_rdata;
  assign Rvalid   = r_rvalid;
  assign Addr_err = r_addr_err;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a DEPTH=24 bypassing zero-register instance and a
// DEPTH=32 non-bypassing instance share one stimulus stream.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] m_rdata, a_rdata;
  logic [1:0]  m_rvalid, a_rvalid;
  logic        m_err, a_err;

  regfile_mp #(.WIDTH(32), .DEPTH(24), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_main (
    .Clk(clk), .Rst_n(rst_n), .We(we), .Waddr(waddr), .Wdata(wdata), .Re(re),
    .Raddr(raddr), .Rdata(m_rdata), .Rvalid(m_rvalid), .Addr_err(m_err)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(0), .BYPASS(0)) u_alt (
    .Clk(clk), .Rst_n(rst_n), .We(we), .Waddr(waddr), .Wdata(wdata), .Re(re),
    .Raddr(raddr), .Rdata(a_rdata), .Rvalid(a_rvalid), .Addr_err(a_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd0, rd1;
    logic [1:0]  rv;
    logic        err;
  } exp_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [1:0]  re;
    logic [4:0]  ra0, ra1;
    exp_t        em;
  } vec_t;

  typedef struct {
    exp_t m;
    exp_t a;
  } sb_t;

  int n_pass = 0;
  int n_total = 0;

  vec_t vecs[$];
  sb_t  sb[$];

  // Reference model of the non-bypassing, no-zero-register instance.
  logic [31:0] am_mem [32];
  logic [31:0] am_rd  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) am_mem[k] = '0;
    am_rd[0] = '0;
    am_rd[1] = '0;
  endtask

  function automatic exp_t mk(input logic [31:0] rd0, input logic [31:0] rd1,
                              input logic [1:0] rv, input logic err);
    exp_t e;
    e.rd0 = rd0; e.rd1 = rd1; e.rv = rv; e.err = err;
    return e;
  endfunction

  task automatic add_vec(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [1:0] r, input logic [4:0] ra0, input logic [4:0] ra1,
                         input exp_t em);
    vec_t v;
    v.we = w; v.wa = wa; v.wd = wd; v.re = r; v.ra0 = ra0; v.ra1 = ra1; v.em = em;
    vecs.push_back(v);
  endtask

  // Called at a falling edge: drive, push expectations, let one rising edge
  // pass, then compare at the next falling edge.
  task automatic drive(input string tag, input vec_t v);
    sb_t s;
    we = v.we; waddr = v.wa; wdata = v.wd; re = v.re; raddr = {v.ra1, v.ra0};
    if (v.re[0]) am_rd[0] = am_mem[v.ra0];
    if (v.re[1]) am_rd[1] = am_mem[v.ra1];
    if (v.we) am_mem[v.wa] = v.wd;
    s.m = v.em;
    s.a = mk(am_rd[0], am_rd[1], v.re, 1'b0);
    sb.push_back(s);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      s = sb.pop_front();
      check({tag, " main rd0"}, m_rdata[31:0], s.m.rd0);
      check({tag, " main rd1"}, m_rdata[63:32], s.m.rd1);
      check({tag, " main rvalid"}, 32'(m_rvalid), 32'(s.m.rv));
      check({tag, " main err"}, 32'(m_err), 32'(s.m.err));
      check({tag, " alt rd0"}, a_rdata[31:0], s.a.rd0);
      check({tag, " alt rd1"}, a_rdata[63:32], s.a.rd1);
      check({tag, " alt rvalid"}, 32'(a_rvalid), 32'(s.a.rv));
      check({tag, " alt err"}, 32'(a_err), 32'(s.a.err));
    end
  endtask

  initial begin
    vec_t v;
    we = 0; waddr = '0; wdata = '0; re = '0; raddr = '0;
    rst_n = 1'b0;
    model_reset();

    // {we, waddr, wdata, re, raddr0, raddr1, expected main-instance outputs}
    add_vec(1, 5'd5,  32'hDEADBEEF, 2'b00, 5'd0,  5'd0, mk(32'h0,        32'h0,        2'b00, 0));
    add_vec(0, 5'd0,  32'h0,        2'b11, 5'd5,  5'd5, mk(32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 0));
    add_vec(1, 5'd7,  32'hA5A5A5A5, 2'b00, 5'd0,  5'd0, mk(32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0));
    add_vec(1, 5'd7,  32'h12345678, 2'b01, 5'd7,  5'd0, mk(32'h12345678, 32'hDEADBEEF, 2'b01, 0));
    add_vec(0, 5'd0,  32'h0,        2'b01, 5'd7,  5'd0, mk(32'h12345678, 32'hDEADBEEF, 2'b01, 0));
    add_vec(1, 5'd0,  32'hFFFFFFFF, 2'b11, 5'd0,  5'd0, mk(32'h0,        32'h0,        2'b11, 0));
    add_vec(0, 5'd0,  32'h0,        2'b11, 5'd0,  5'd0, mk(32'h0,        32'h0,        2'b11, 0));
    add_vec(1, 5'd30, 32'h1,        2'b11, 5'd25, 5'd5, mk(32'h0,        32'hDEADBEEF, 2'b11, 1));
    add_vec(0, 5'd0,  32'h0,        2'b00, 5'd0,  5'd0, mk(32'h0,        32'hDEADBEEF, 2'b00, 0));
    add_vec(1, 5'd3,  32'h33,       2'b00, 5'd0,  5'd0, mk(32'h0,        32'hDEADBEEF, 2'b00, 0));
    add_vec(0, 5'd0,  32'h0,        2'b01, 5'd3,  5'd0, mk(32'h33,       32'hDEADBEEF, 2'b01, 0));
    add_vec(1, 5'd3,  32'h44,       2'b00, 5'd3,  5'd0, mk(32'h33,       32'hDEADBEEF, 2'b00, 0));
    add_vec(0, 5'd0,  32'h0,        2'b00, 5'd3,  5'd0, mk(32'h33,       32'hDEADBEEF, 2'b00, 0));
    add_vec(0, 5'd0,  32'h0,        2'b00, 5'd3,  5'd0, mk(32'h33,       32'hDEADBEEF, 2'b00, 0));
    add_vec(0, 5'd0,  32'h0,        2'b00, 5'd3,  5'd0, mk(32'h33,       32'hDEADBEEF, 2'b00, 0));
    add_vec(1, 5'd23, 32'h0000CAFE, 2'b11, 5'd23, 5'd3, mk(32'h0000CAFE, 32'h44,       2'b11, 0));
    add_vec(1, 5'd24, 32'h00000BAD, 2'b01, 5'd24, 5'd0, mk(32'h0,        32'h44,       2'b01, 1));
    add_vec(0, 5'd0,  32'h0,        2'b11, 5'd23, 5'd24, mk(32'h0000CAFE, 32'h0,       2'b11, 1));
    add_vec(0, 5'd0,  32'h0,        2'b00, 5'd0,  5'd0, mk(32'h0000CAFE, 32'h0,        2'b00, 0));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset main rdata", m_rdata[31:0] | m_rdata[63:32], 32'h0);
    check("reset main rvalid", 32'(m_rvalid), 32'h0);

    for (int i = 0; i < vecs.size(); i++)
      drive($sformatf("vec%0d", i), vecs[i]);

    // Mid-cycle asynchronous reset while Rdata holds 0xCAFE.
    #2 rst_n = 1'b0;
    #1;
    check("async rst main rd0", m_rdata[31:0], 32'h0);
    check("async rst main rvalid/err", {30'h0, m_rvalid} | 32'(m_err), 32'h0);
    check("async rst alt rd0", a_rdata[31:0], 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Every address reads back zero after reset; high addresses flag errors
    // on the DEPTH=24 instance only.
    for (int a = 0; a < 32; a++) begin
      v.we = 0; v.wa = '0; v.wd = '0; v.re = 2'b11;
      v.ra0 = 5'(a); v.ra1 = 5'(31 - a);
      v.em = mk(32'h0, 32'h0, 2'b11, (a >= 24) || (a <= 7));
      drive($sformatf("sweep%0d", a), v);
    end

    we = 0; re = '0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
